// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 pin with falling-edge detect
// taken from the second stage.
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, one byte shifted
// out on device clock falls, then the device ACK is checked.
//
// state     | meaning
// IDLE      | lines released, ready for a byte
// INHIBIT   | clock held low; start bit driven on the last cycle
// SEND      | clock released; next bit loaded on each device clock fall
// ACK       | lines released; ACK level sampled on the next fall
// WAIT_IDLE | ACK seen; waiting for clock and data to return high
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       LAST_FALL    = 4'(FRAME_BITS - 2);

  ps2_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  clk_level, clk_fall;
  logic                  data_level, data_fall_unused;
  logic                  tmr_done;

  ps2_sync_edge u_sync_clk (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pin   (ps2_clk_i),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pin   (ps2_data_i),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
    end
  end

  // One down-counter serves as inhibit timer, then as the frame timeout.
  assign tmr_done = (tmr_q == '0);

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    bit_cnt_d     = bit_cnt_q;
    tmr_d         = tmr_q;
    tx_ready_o    = 1'b0;
    ps2_clk_oe_o  = 1'b0;
    ps2_data_oe_o = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;

    case (state_q)
      IDLE: begin
        tx_ready_o = 1'b1;
        if (tx_valid_i) begin
          frame_d   = {1'b1, odd_parity(tx_data_i), tx_data_i, 1'b0};
          bit_cnt_d = '0;
          tmr_d     = INHIBIT_LOAD;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
        if (tmr_done) begin
          ps2_data_oe_o = 1'b1;
          tmr_d         = TIMEOUT_LOAD;
          state_d       = SEND;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      SEND: begin
        if (tmr_done) begin
          err_o   = 1'b1;
          state_d = IDLE;
        end else begin
          ps2_data_oe_o = ~frame_q[0];
          tmr_d         = tmr_q - TMR_W'(1);
          if (clk_fall) begin
            frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_FALL) state_d = ACK;
          end
        end
      end
      ACK: begin
        if (tmr_done) begin
          err_o   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
          if (clk_fall) begin
            if (data_level) begin
              err_o   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (tmr_done) begin
          err_o   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
          if (clk_level && data_level) begin
            done_o  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device on wired-AND lines, a frame model
// built from the protocol rules, table vectors, corner sequences and random frames.
module tb_ps2_tx;

  localparam int INH       = 8;
  localparam int HP        = 20;
  localparam int TMO_LONG  = 2000;
  localparam int TMO_SHORT = 200;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sel_to = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  logic valid_a, rdy_a, clk_oe_a, data_oe_a, done_a, err_a;
  logic valid_b, rdy_b, clk_oe_b, data_oe_b, done_b, err_b;
  logic m_ready, m_clk_oe, m_data_oe, m_done, m_err;
  logic clk_line, data_line;

  int total = 0;
  int bad = 0;
  int n_done = 0, n_err = 0, oe_hi = 0, send_off = 0, err_off = 0, ready_hi = 0;
  logic prev_pulse = 1'b0, prev_clk_oe = 1'b0;
  logic smp[$];

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;
  vec_t vecs[6];

  assign valid_a   = tx_valid & ~sel_to;
  assign valid_b   = tx_valid & sel_to;
  assign m_ready   = sel_to ? rdy_b     : rdy_a;
  assign m_clk_oe  = sel_to ? clk_oe_b  : clk_oe_a;
  assign m_data_oe = sel_to ? data_oe_b : data_oe_a;
  assign m_done    = sel_to ? done_b    : done_a;
  assign m_err     = sel_to ? err_b     : err_a;
  assign clk_line  = ~(m_clk_oe | dev_clk_low);
  assign data_line = ~(m_data_oe | dev_data_low);

  always #5 clk_i = ~clk_i;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO_LONG)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_valid_i(valid_a), .tx_data_i(tx_data),
    .tx_ready_o(rdy_a), .ps2_clk_i(clk_line), .ps2_data_i(data_line),
    .ps2_clk_oe_o(clk_oe_a), .ps2_data_oe_o(data_oe_a), .done_o(done_a), .err_o(err_a)
  );

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO_SHORT)) u_dut_to (
    .clk_i(clk_i), .rst_i(rst_i), .tx_valid_i(valid_b), .tx_data_i(tx_data),
    .tx_ready_o(rdy_b), .ps2_clk_i(clk_line), .ps2_data_i(data_line),
    .ps2_clk_oe_o(clk_oe_b), .ps2_data_oe_o(data_oe_b), .done_o(done_b), .err_o(err_b)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // The device latches the data line on every rising edge of the wired clock.
  always @(posedge clk_line) smp.push_back(data_line);

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic [10:0] pack_smp();
    logic [10:0] g = 'x;
    for (int i = 0; i < 11; i++) if (i < smp.size()) g[i] = smp[i];
    return g;
  endfunction

  initial begin
    forever begin
      @(negedge clk_i);
      if (prev_pulse) begin
        check("ready_after_pulse", m_ready, 1);
        check("oe_after_pulse", {m_clk_oe, m_data_oe}, 0);
      end
      if (m_done === 1'b1 || m_err === 1'b1) check("pulse_exclusive", m_done & m_err, 0);
      prev_pulse = (m_done === 1'b1) || (m_err === 1'b1);
      if (m_clk_oe === 1'b1) oe_hi++;
      if (m_ready === 1'b1) ready_hi++;
      if (prev_clk_oe && m_clk_oe === 1'b0) send_off = 0;
      else send_off++;
      prev_clk_oe = (m_clk_oe === 1'b1);
      if (m_done === 1'b1) n_done++;
      if (m_err === 1'b1) begin
        n_err++;
        err_off = send_off;
      end
    end
  end

  task automatic device(input int hp, input int nfall, input bit ack);
    int k = 0;
    while (m_clk_oe !== 1'b1 && k < 100) begin @(negedge clk_i); k++; end
    while (m_clk_oe !== 1'b0 && k < 100) begin @(negedge clk_i); k++; end
    if (k >= 100) begin
      check("clk_release", m_clk_oe, 0);
      return;
    end
    repeat (hp) @(negedge clk_i);
    for (int i = 0; i < nfall; i++) begin
      dev_clk_low = 1'b1;
      repeat (hp) @(negedge clk_i);
      dev_clk_low = 1'b0;
      repeat (hp) @(negedge clk_i);
    end
    if (nfall == 10) begin
      repeat (hp / 2) @(negedge clk_i);
      dev_data_low = ack;
      repeat (hp / 2) @(negedge clk_i);
      dev_clk_low = 1'b1;
      repeat (hp) @(negedge clk_i);
      dev_clk_low = 1'b0;
      repeat (hp / 2) @(negedge clk_i);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (m_ready !== 1'b1 && k < 5000) begin @(negedge clk_i); k++; end
    if (k >= 5000) check("ready_wait", m_ready, 1);
  endtask

  task automatic wait_pulse(input int d0, input int e0, input int limit);
    int k = 0;
    while (n_done == d0 && n_err == e0 && k < limit) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    if (k >= limit) check("pulse_wait", n_done + n_err - d0 - e0, 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int hp, input bit ack,
                            output logic [10:0] bits, output int nd, output int ne);
    int d0, e0;
    wait_ready();
    d0 = n_done;
    e0 = n_err;
    smp.delete();
    oe_hi = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_i);
    tx_valid = 1'b0;
    device(hp, 10, ack);
    wait_pulse(d0, e0, 200);
    bits = pack_smp();
    repeat (2) @(negedge clk_i);
    nd = n_done - d0;
    ne = n_err - e0;
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  d;
    int nd, ne, d0, e0, hp;
    bit ack;

    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1, 0};
    vecs[4] = '{8'hED, 1'b1, 1'b1, 1, 0};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 0, 1};

    repeat (3) @(negedge clk_i);
    check("rst_ready", m_ready, 1);
    check("rst_oe", {m_clk_oe, m_data_oe}, 0);
    check("rst_pulses", {m_done, m_err}, 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, HP, vecs[i].ack, bits, nd, ne);
      check($sformatf("vec%0d_done", i), nd, vecs[i].exp_done);
      check($sformatf("vec%0d_err", i), ne, vecs[i].exp_err);
      check($sformatf("vec%0d_parity", i), bits[9], vecs[i].exp_par);
      check($sformatf("vec%0d_bits", i), bits, model_frame(vecs[i].data));
      check($sformatf("vec%0d_inhibit", i), oe_hi, INH);
    end

    // tx_valid held high across two bytes: the second waits for done_o.
    wait_ready();
    d0 = n_done;
    e0 = n_err;
    smp.delete();
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk_i);
    #1;
    check("busy_accept_ed", m_ready, 0);
    tx_data  = 8'hF4;
    ready_hi = 0;
    device(HP, 10, 1'b1);
    wait_pulse(d0, e0, 200);
    check("busy_done1", n_done - d0, 1);
    check("busy_no_early_accept", ready_hi, 0);
    check("busy_bits_ed", pack_smp(), model_frame(8'hED));
    smp.delete();
    d0 = n_done;
    @(negedge clk_i);
    #1;
    check("busy_ready_after_done", m_ready, 1);
    @(negedge clk_i);
    #1;
    check("busy_accept_f4", m_ready, 0);
    tx_valid = 1'b0;
    device(HP, 10, 1'b1);
    wait_pulse(d0, e0, 200);
    check("busy_done2", n_done - d0, 1);
    check("busy_bits_f4", pack_smp(), model_frame(8'hF4));
    repeat (2) @(negedge clk_i);

    // Device stops clocking after four falls on the short-timeout instance.
    sel_to = 1'b1;
    @(negedge clk_i);
    wait_ready();
    d0 = n_done;
    e0 = n_err;
    tx_data  = 8'h35;
    tx_valid = 1'b1;
    @(negedge clk_i);
    tx_valid = 1'b0;
    device(HP, 4, 1'b0);
    #1;
    check("tmo_pre_oe", m_data_oe, 1);
    wait_pulse(d0, e0, 300);
    check("tmo_err", n_err - e0, 1);
    check("tmo_done", n_done - d0, 0);
    check("tmo_offset", err_off, TMO_SHORT);
    @(negedge clk_i);
    #1;
    check("tmo_release", {m_clk_oe, m_data_oe}, 0);
    repeat (2) @(negedge clk_i);
    sel_to = 1'b0;
    @(negedge clk_i);

    // Reset asserted between clock edges after the fifth fall.
    wait_ready();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk_i);
    tx_valid = 1'b0;
    device(HP, 5, 1'b0);
    check("rst_mid_pre_oe", m_data_oe, 1);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_mid_oe", {m_clk_oe, m_data_oe}, 0);
    check("rst_mid_ready", m_ready, 1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_release_ready", m_ready, 1);
    send_frame(8'hFF, HP, 1'b1, bits, nd, ne);
    check("rst_ff_done", nd, 1);
    check("rst_ff_err", ne, 0);
    check("rst_ff_bits", bits, model_frame(8'hFF));

    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom_range(0, 255));
      hp  = $urandom_range(12, 30);
      ack = ($urandom_range(0, 3) != 0);
      send_frame(d, hp, ack, bits, nd, ne);
      check($sformatf("rnd%0d_done", i), nd, ack ? 1 : 0);
      check($sformatf("rnd%0d_err", i), ne, ack ? 0 : 1);
      check($sformatf("rnd%0d_bits", i), bits, model_frame(d));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
